sim_end_writer: RTL and testbench

- Hardware producer of the simulation end-of-test signature in data memory (DM).
- On a start pulse from the CPU-side control logic, it arbitrates for the DM SRAM port and writes three words:
  - the 64-bit cycle count, low word then high word, immediately after the result area;
  - the end code at the end-marker address, which the bench polls.
- Sits beside the core on the DM port mux; the core releases the port when grant is given.

---
 rtl/sim_end_writer_if.sv | 32 +++
 rtl/sim_end_writer.sv | 171 +++++++++++++++++
 tb/tb_sim_end_writer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_end_writer_if.sv
// DM port, control and status bundle of sim_end_writer.
// master = the signature writer, slave = CPU-side control / port mux / memory.
interface sim_end_writer_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              start;
   logic [ADDR_W-1:0] num_words;
   logic              bus_req;
   logic              bus_gnt;
   logic              dm_cs;
   logic              dm_oe;
   logic [3:0]        dm_web;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_di;
   logic [31:0]       dm_do;
   logic              busy;
   logic              done;
   logic              verify_err;
   logic [63:0]       cycle_cnt;

   modport master (
      input  start, num_words, bus_gnt, dm_do,
      output bus_req, dm_cs, dm_oe, dm_web, dm_addr, dm_di,
             busy, done, verify_err, cycle_cnt
   );

   modport slave (
      output start, num_words, bus_gnt, dm_do,
      input  bus_req, dm_cs, dm_oe, dm_web, dm_addr, dm_di,
             busy, done, verify_err, cycle_cnt
   );
endinterface

// File: rtl/sim_end_writer.sv
// Writes the end-of-test signature (64-bit cycle count, then END_CODE) into DM.
// Optional SIM_END_VERIFY_EN adds a read-back of the end marker with up to 3 retries.
module sim_end_writer #(
   parameter int unsigned       ADDR_W          = 14,
   parameter logic [ADDR_W-1:0] TEST_START_ADDR = ADDR_W'(32'h2000),
   parameter logic [ADDR_W-1:0] SIM_END_ADDR    = ADDR_W'(32'h3fff),
   parameter logic [31:0]       END_CODE        = 32'hFFFF_FFFF
) (
   input logic              clk,
   input logic              rst,
   sim_end_writer_if.master bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 64;
   localparam int unsigned WEB_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WR_LO, S_WR_HI, S_WR_END, S_RD_CHK, S_CMP, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cycle_cnt_q;
   logic [CNT_W-1:0]    snap_q;
   logic [ADDR_W-1:0]   num_q;
   logic [ADDR_W-1:0]   lo_addr, hi_addr;
   logic                lo_skip, hi_skip, accept;
   logic                verify_err_c;

   logic                req_c, cs_c, oe_c, busy_c, done_c;
   logic [WEB_W-1:0]    web_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [DATA_W-1:0]   di_c;

   assign accept  = (state_q == S_IDLE) && bus.start;
   assign lo_addr = TEST_START_ADDR + num_q;
   assign hi_addr = lo_addr + ADDR_W'(1);
   // A count word landing on the marker is dropped so END_CODE stays the last value there.
   assign lo_skip = (lo_addr == SIM_END_ADDR);
   assign hi_skip = (hi_addr == SIM_END_ADDR);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Free-running counter and start-time snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         snap_q      <= '0;
         num_q       <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (accept) begin
            snap_q <= cycle_cnt_q + CNT_W'(1);
            num_q  <= bus.num_words;
         end
      end
   end

`ifdef SIM_END_VERIFY_EN
   logic [1:0] retry_q;
   logic       verify_err_q;
   logic       rd_match;

   assign rd_match     = (bus.dm_do == END_CODE);
   assign verify_err_c = verify_err_q;

   // Retry counter and sticky error for the marker read-back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retry_q      <= '0;
         verify_err_q <= 1'b0;
      end else if (accept) begin
         retry_q <= '0;
      end else if ((state_q == S_CMP) && !rd_match) begin
         if (retry_q == 2'd3) verify_err_q <= 1'b1;
         else                 retry_q      <= retry_q + 2'd1;
      end
   end
`else
   logic unused_dm_do;
   assign unused_dm_do = ^bus.dm_do;
   assign verify_err_c = 1'b0;
`endif

   // Next-state logic; write states hold while the grant is withdrawn
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_REQ;
         S_REQ:    if (bus.bus_gnt) state_d = S_WR_LO;
         S_WR_LO:  if (lo_skip || bus.bus_gnt) state_d = S_WR_HI;
         S_WR_HI:  if (hi_skip || bus.bus_gnt) state_d = S_WR_END;
`ifdef SIM_END_VERIFY_EN
         S_WR_END: if (bus.bus_gnt) state_d = S_RD_CHK;
         S_RD_CHK: if (bus.bus_gnt) state_d = S_CMP;
         S_CMP:    state_d = (rd_match || (retry_q == 2'd3)) ? S_DONE : S_WR_END;
`else
         S_WR_END: if (bus.bus_gnt) state_d = S_DONE;
`endif
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode; strobes are gated by the live grant
   always_comb begin
      req_c  = 1'b0;
      cs_c   = 1'b0;
      oe_c   = 1'b0;
      web_c  = '1;
      addr_c = '0;
      di_c   = '0;
      busy_c = (state_q != S_IDLE);
      done_c = 1'b0;
      case (state_q)
         S_REQ: req_c = 1'b1;
         S_WR_LO: begin
            req_c = 1'b1;
            if (bus.bus_gnt && !lo_skip) begin
               cs_c   = 1'b1;
               web_c  = '0;
               addr_c = lo_addr;
               di_c   = snap_q[DATA_W-1:0];
            end
         end
         S_WR_HI: begin
            req_c = 1'b1;
            if (bus.bus_gnt && !hi_skip) begin
               cs_c   = 1'b1;
               web_c  = '0;
               addr_c = hi_addr;
               di_c   = snap_q[CNT_W-1:DATA_W];
            end
         end
         S_WR_END: begin
            req_c = 1'b1;
            if (bus.bus_gnt) begin
               cs_c   = 1'b1;
               web_c  = '0;
               addr_c = SIM_END_ADDR;
               di_c   = END_CODE;
            end
         end
         S_RD_CHK: begin
            req_c = 1'b1;
            if (bus.bus_gnt) begin
               cs_c   = 1'b1;
               oe_c   = 1'b1;
               addr_c = SIM_END_ADDR;
            end
         end
         S_CMP:  req_c  = 1'b1;
         S_DONE: done_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.bus_req    = req_c;
   assign bus.dm_cs      = cs_c;
   assign bus.dm_oe      = oe_c;
   assign bus.dm_web     = web_c;
   assign bus.dm_addr    = addr_c;
   assign bus.dm_di      = di_c;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.verify_err = verify_err_c;
   assign bus.cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_sim_end_writer.sv
// Directed self-checking bench for sim_end_writer: DM writes are logged at the
// falling edge and checked against hand-computed addresses, data and cycles.
module tb_sim_end_writer;
   localparam int unsigned ADDR_W   = 14;
   localparam logic [31:0] END_CODE = 32'hFFFF_FFFF;
`ifdef SIM_END_VERIFY_EN
   localparam int VLAT = 2;
`else
   localparam int VLAT = 0;
`endif

   logic clk = 1'b0;
   logic rst;

   sim_end_writer_if #(.ADDR_W(ADDR_W)) bus ();
   sim_end_writer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference cycle count: value cycle_cnt should show during each cycle
   logic [63:0] tb_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cnt <= '0;
      else     tb_cnt <= tb_cnt + 64'd1;
   end

   int tests_run    = 0;
   int tests_failed = 0;

   logic [ADDR_W-1:0] wr_addr [$];
   logic [31:0]       wr_data [$];
   longint            wr_cyc  [$];
   logic [31:0]       mem [logic [ADDR_W-1:0]];
   int                rd_count, done_count, gnt_viol;
   longint            done_cyc;

   // Bus monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.dm_cs && (bus.dm_web == 4'h0)) begin
            wr_addr.push_back(bus.dm_addr);
            wr_data.push_back(bus.dm_di);
            wr_cyc.push_back(longint'(tb_cnt));
            mem[bus.dm_addr] = bus.dm_di;
         end
         if (bus.dm_cs && !bus.bus_gnt) gnt_viol++;
         if (bus.dm_cs && bus.dm_oe)    rd_count++;
         if (bus.done) begin
            done_count++;
            done_cyc = longint'(tb_cnt);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      rd_count   = 0;
      gnt_viol   = 0;
      done_count = 0;
      done_cyc   = -1;
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_dm_cs"},     64'(bus.dm_cs),      64'd0);
      check({pfx, "_dm_oe"},     64'(bus.dm_oe),      64'd0);
      check({pfx, "_dm_web"},    64'(bus.dm_web),     64'hF);
      check({pfx, "_dm_addr"},   64'(bus.dm_addr),    64'd0);
      check({pfx, "_dm_di"},     64'(bus.dm_di),      64'd0);
      check({pfx, "_bus_req"},   64'(bus.bus_req),    64'd0);
      check({pfx, "_busy"},      64'(bus.busy),       64'd0);
      check({pfx, "_done"},      64'(bus.done),       64'd0);
      check({pfx, "_verr"},      64'(bus.verify_err), 64'd0);
      check({pfx, "_cycle_cnt"}, bus.cycle_cnt,       64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2);
   endtask

   // Pulse start for one cycle; returns the snapshot the DUT must latch
   task automatic kick(input logic [ADDR_W-1:0] num, output logic [63:0] snap, output longint c);
      bus.num_words = num;
      bus.start     = 1'b1;
      snap          = tb_cnt + 64'd1;
      c             = longint'(tb_cnt);
      cyc(1);
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int base = done_count;
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         cyc(1);
         if (done_count > base) seen = 1'b1;
      end
      check("done_seen", 64'(seen), 64'd1);
   endtask

   function automatic int count_addr(input logic [ADDR_W-1:0] a);
      int n = 0;
      foreach (wr_addr[i]) if (wr_addr[i] == a) n++;
      return n;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] snap, snap_b;
      longint      c;

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_words = '0;
      bus.bus_gnt   = 1'b1;
      bus.dm_do     = END_CODE;
      clear_log();
      cyc(3);
      check_reset("rst0");
      rst = 1'b0;

      // Basic run: start in cycle 99 -> snapshot 100, num_words 10
      for (int i = 0; i < 200 && tb_cnt < 64'd99; i++) cyc(1);
      check("t1_cycle_cnt", bus.cycle_cnt, 64'd99);
      kick(14'd10, snap, c);
      check("t1_busy_req", 64'(bus.busy), 64'd1);
      check("t1_bus_req",  64'(bus.bus_req), 64'd1);
      wait_done(40);
      cyc(5);
      check("t1_nwr", 64'(wr_addr.size()), 64'd3);
      if (wr_addr.size() == 3) begin
         check("t1_lo_addr", 64'(wr_addr[0]), 64'h200A);
         check("t1_lo_data", 64'(wr_data[0]), 64'd100);
         check("t1_hi_addr", 64'(wr_addr[1]), 64'h200B);
         check("t1_hi_data", 64'(wr_data[1]), 64'd0);
         check("t1_end_addr", 64'(wr_addr[2]), 64'h3FFF);
         check("t1_end_data", 64'(wr_data[2]), 64'hFFFF_FFFF);
         check("t1_lo_cyc", 64'(wr_cyc[0]), 64'd101);
         check("t1_end_cyc", 64'(wr_cyc[2]), 64'd103);
      end
      check("t1_done_cyc", 64'(done_cyc), 64'(104 + VLAT));
      check("t1_idle_busy", 64'(bus.busy), 64'd0);

      // Grant withdrawn for 3 cycles while in WR_HI
      clear_log();
      kick(14'd5, snap, c);
      cyc(1);
      cyc(1);
      bus.bus_gnt = 1'b0;
      cyc(3);
      bus.bus_gnt = 1'b1;
      wait_done(40);
      cyc(2);
      check("t2_nwr", 64'(wr_addr.size()), 64'd3);
      check("t2_gnt_viol", 64'(gnt_viol), 64'd0);
      if (wr_addr.size() == 3) begin
         check("t2_lo", {18'd0, wr_addr[0], wr_data[0]}, {18'd0, 14'h2005, snap[31:0]});
         check("t2_hi", {18'd0, wr_addr[1], wr_data[1]}, {18'd0, 14'h2006, snap[63:32]});
         check("t2_hi_gap", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
         check("t2_end_addr", 64'(wr_addr[2]), 64'h3FFF);
      end

      // lo_addr lands on the marker: lo suppressed, hi wraps to 0
      clear_log();
      kick(14'h1FFF, snap, c);
      wait_done(40);
      cyc(2);
      check("t3_nwr", 64'(wr_addr.size()), 64'd2);
      if (wr_addr.size() == 2) begin
         check("t3_hi", {18'd0, wr_addr[0], wr_data[0]}, {18'd0, 14'h0000, snap[63:32]});
         check("t3_hi_cyc", 64'(wr_cyc[0]), 64'(c + 3));
         check("t3_end_cyc", 64'(wr_cyc[1]), 64'(c + 4));
      end
      check("t3_marker", 64'(mem[14'h3FFF]), 64'hFFFF_FFFF);

      // hi_addr lands on the marker: hi suppressed
      clear_log();
      kick(14'h1FFE, snap, c);
      wait_done(40);
      cyc(2);
      check("t3b_nwr", 64'(wr_addr.size()), 64'd2);
      if (wr_addr.size() == 2) begin
         check("t3b_lo", {18'd0, wr_addr[0], wr_data[0]}, {18'd0, 14'h3FFE, snap[31:0]});
         check("t3b_end", {18'd0, wr_addr[1], wr_data[1]}, {18'd0, 14'h3FFF, END_CODE});
      end

      // start in WR_LO and DONE ignored; start right after DONE accepted
      clear_log();
      kick(14'd1, snap, c);                  // REQ now
      cyc(1);                                // WR_LO
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1 + VLAT);                         // WR_END .. CMP
      cyc(1);                                // DONE
      bus.start = 1'b1;
      cyc(1);                                // IDLE
      check("t4_idle_busy", 64'(bus.busy), 64'd0);
      snap_b = tb_cnt + 64'd1;
      check("t4_snap_b", snap_b, 64'(c + 7 + VLAT));
      cyc(1);
      bus.start = 1'b0;
      wait_done(40);
      cyc(4);
      check("t4_ndone", 64'(done_count), 64'd2);
      check("t4_nwr", 64'(wr_addr.size()), 64'd6);
      if (wr_addr.size() == 6) begin
         check("t4_a_lo", 64'(wr_data[0]), 64'(snap[31:0]));
         check("t4_b_lo", {18'd0, wr_addr[3], wr_data[3]}, {18'd0, 14'h2001, snap_b[31:0]});
      end

      // Reset while in WR_HI, then a clean run with num_words = 0
      clear_log();
      kick(14'd7, snap, c);
      cyc(1);                                // WR_LO
      cyc(1);                                // WR_HI
      rst = 1'b1;
      #1;
      check_reset("t5");
      cyc(2);
      check("t5_partial", 64'(wr_addr.size()), 64'd1);
      rst = 1'b0;
      cyc(2);
      clear_log();
      kick(14'd0, snap, c);
      wait_done(40);
      cyc(2);
      check("t5_nwr", 64'(wr_addr.size()), 64'd3);
      if (wr_addr.size() == 3) begin
         check("t5_lo", {18'd0, wr_addr[0], wr_data[0]}, {18'd0, 14'h2000, snap[31:0]});
         check("t5_hi", {18'd0, wr_addr[1], wr_data[1]}, {18'd0, 14'h2001, snap[63:32]});
      end

`ifdef SIM_END_VERIFY_EN
      // Read-back always wrong: 4 marker writes, error raised, done still pulses
      do_reset();
      clear_log();
      bus.dm_do = 32'd0;
      kick(14'd3, snap, c);
      wait_done(80);
      cyc(3);
      check("t6_end_writes", 64'(count_addr(14'h3FFF)), 64'd4);
      check("t6_reads", 64'(rd_count), 64'd4);
      check("t6_verr", 64'(bus.verify_err), 64'd1);
      check("t6_ndone", 64'(done_count), 64'd1);
      // Read-back correct: one read, no error
      do_reset();
      clear_log();
      bus.dm_do = END_CODE;
      kick(14'd3, snap, c);
      wait_done(40);
      cyc(3);
      check("t6b_end_writes", 64'(count_addr(14'h3FFF)), 64'd1);
      check("t6b_reads", 64'(rd_count), 64'd1);
      check("t6b_verr", 64'(bus.verify_err), 64'd0);
`else
      check("t6_verr_tied", 64'(bus.verify_err), 64'd0);
      check("t6_no_reads", 64'(rd_count), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
